// File: rtl/pcie_fifo_pkg.sv
// rtl/pcie_fifo_pkg.sv - gray-code helpers and limits for the host-command async FIFO
package pcie_fifo_pkg;

   localparam int LP_SYNC_STAGES_MAX = 4;
   localparam int LP_PTR_W_MAX       = 11;

   typedef logic [LP_PTR_W_MAX-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Narrower pointers are zero-extended into ptr_t, which leaves the low bits of the result exact.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[LP_PTR_W_MAX-1] = g[LP_PTR_W_MAX-1];
      for (int i = LP_PTR_W_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/pcie_fifo_ptr_sync.sv
// rtl/pcie_fifo_ptr_sync.sv - gray-encodes a pointer, carries it across clock domains, decodes it
// The gray register is loaded from the next pointer so it changes on the same edge as the pointer itself.
module pcie_fifo_ptr_sync
   import pcie_fifo_pkg::*;
#(
   parameter int P_PTR_WIDTH   = 8,
   parameter int P_SYNC_STAGES = 2
) (
   input  logic                   src_clk,
   input  logic                   src_rst_n,
   input  logic [P_PTR_WIDTH-1:0] src_ptr_nxt,
   input  logic                   dst_clk,
   input  logic                   dst_rst_n,
   output logic [P_PTR_WIDTH-1:0] dst_ptr
);

   localparam int LP_STAGES = (P_SYNC_STAGES > LP_SYNC_STAGES_MAX) ? LP_SYNC_STAGES_MAX :
                              (P_SYNC_STAGES < 2)                  ? 2 : P_SYNC_STAGES;

   logic [P_PTR_WIDTH-1:0] src_gray;
   logic [P_PTR_WIDTH-1:0] sync_q [LP_STAGES];

   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) begin
         src_gray <= '0;
      end else begin
         src_gray <= P_PTR_WIDTH'(bin2gray(ptr_t'(src_ptr_nxt)));
      end
   end

   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         for (int i = 0; i < LP_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= src_gray;
         for (int i = 1; i < LP_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign dst_ptr = P_PTR_WIDTH'(gray2bin(ptr_t'(sync_q[LP_STAGES-1])));

endmodule

// File: rtl/pcie_hcmd_async_fifo.sv
// rtl/pcie_hcmd_async_fifo.sv - dual-clock host-command tag FIFO with fill levels and sticky error flags
// Look-ahead read: rd_data always holds the head entry while empty_n is high.
module pcie_hcmd_async_fifo
   import pcie_fifo_pkg::*;
#(
   parameter int P_FIFO_DATA_WIDTH  = 22,
   parameter int P_FIFO_DEPTH_WIDTH = 7,
   parameter int P_SYNC_STAGES      = 2,
   parameter int P_AFULL_MARGIN     = 4,
   parameter int P_AEMPTY_MARGIN    = 2
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst_n,
   input  logic                          rd_clk,
   input  logic                          rd_rst_n,
   input  logic                          wr_en,
   input  logic [P_FIFO_DATA_WIDTH-1:0]  wr_data,
   output logic                          full_n,
   output logic                          almost_full,
   output logic [P_FIFO_DEPTH_WIDTH:0]   wr_count,
   output logic                          wr_overflow,
   input  logic                          rd_en,
   output logic [P_FIFO_DATA_WIDTH-1:0]  rd_data,
   output logic                          empty_n,
   output logic                          almost_empty,
   output logic [P_FIFO_DEPTH_WIDTH:0]   rd_count,
   output logic                          rd_underflow
);

   localparam int              D        = P_FIFO_DEPTH_WIDTH;
   localparam int              PW       = D + 1;
   localparam logic [PW-1:0]   LP_DEPTH = {1'b1, {D{1'b0}}};

   logic [P_FIFO_DATA_WIDTH-1:0] mem [2**D];
   logic [PW-1:0] rear, rear_nxt, rear_sync;
   logic [PW-1:0] front, front_nxt, front_sync;
   logic          wr_fire, rd_fire;

   // Write domain
   assign wr_fire     = wr_en & full_n;
   assign rear_nxt    = rear + PW'(wr_fire);
   assign wr_count    = rear - front_sync;
   assign full_n      = (wr_count != LP_DEPTH);
   assign almost_full = (int'(LP_DEPTH - wr_count) <= P_AFULL_MARGIN);

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         rear        <= '0;
         wr_overflow <= 1'b0;
      end else begin
         rear <= rear_nxt;
         if (wr_en && !full_n) begin
            wr_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (wr_fire) begin
         mem[rear[D-1:0]] <= wr_data;
      end
   end

   // Read domain; the RAM is addressed with the post-pop pointer so the new head is ready next edge
   assign rd_fire      = rd_en & empty_n;
   assign front_nxt    = front + PW'(rd_fire);
   assign rd_count     = rear_sync - front;
   assign empty_n      = (rd_count != '0);
   assign almost_empty = (int'(rd_count) <= P_AEMPTY_MARGIN);

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         front        <= '0;
         rd_underflow <= 1'b0;
      end else begin
         front <= front_nxt;
         if (rd_en && !empty_n) begin
            rd_underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge rd_clk) begin
      rd_data <= mem[front_nxt[D-1:0]];
   end

   pcie_fifo_ptr_sync #(
      .P_PTR_WIDTH   (PW),
      .P_SYNC_STAGES (P_SYNC_STAGES)
   ) u_rear_sync (
      .src_clk     (wr_clk),
      .src_rst_n   (wr_rst_n),
      .src_ptr_nxt (rear_nxt),
      .dst_clk     (rd_clk),
      .dst_rst_n   (rd_rst_n),
      .dst_ptr     (rear_sync)
   );

   pcie_fifo_ptr_sync #(
      .P_PTR_WIDTH   (PW),
      .P_SYNC_STAGES (P_SYNC_STAGES)
   ) u_front_sync (
      .src_clk     (rd_clk),
      .src_rst_n   (rd_rst_n),
      .src_ptr_nxt (front_nxt),
      .dst_clk     (wr_clk),
      .dst_rst_n   (wr_rst_n),
      .dst_ptr     (front_sync)
   );

endmodule

// File: tb/tb_pcie_hcmd_async_fifo.sv
// tb/tb_pcie_hcmd_async_fifo.sv - self-checking bench for pcie_hcmd_async_fifo against a queue model
module tb_pcie_hcmd_async_fifo;

   localparam int DW    = 22;
   localparam int D     = 4;
   localparam int DEPTH = 16;

   logic          wr_clk = 1'b0, rd_clk = 1'b0;
   logic          wr_rst_n = 1'b0, rd_rst_n = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          full_n, almost_full, wr_overflow, empty_n, almost_empty, rd_underflow;
   logic [D:0]    wr_count, rd_count;

   int wr_half = 4;
   int rd_half = 10;
   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] sb [$];
   int            push_dec, pop_dec;
   bit            wr_done;

   pcie_hcmd_async_fifo #(
      .P_FIFO_DATA_WIDTH  (DW),
      .P_FIFO_DEPTH_WIDTH (D),
      .P_SYNC_STAGES      (2),
      .P_AFULL_MARGIN     (4),
      .P_AEMPTY_MARGIN    (2)
   ) dut (
      .wr_clk       (wr_clk),
      .wr_rst_n     (wr_rst_n),
      .rd_clk       (rd_clk),
      .rd_rst_n     (rd_rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full_n       (full_n),
      .almost_full  (almost_full),
      .wr_count     (wr_count),
      .wr_overflow  (wr_overflow),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty_n      (empty_n),
      .almost_empty (almost_empty),
      .rd_count     (rd_count),
      .rd_underflow (rd_underflow)
   );

   // Even half periods with a 1-unit offset keep the two clocks' edges apart.
   always #(wr_half) wr_clk = ~wr_clk;
   initial begin
      #1;
      forever #(rd_half) rd_clk = ~rd_clk;
   end

   task automatic push(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge wr_clk);
      wr_en   = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge rd_clk);
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      wr_en = 1'b0; rd_en = 1'b0;
      wr_rst_n = 1'b0; rd_rst_n = 1'b0;
      repeat (3) @(negedge rd_clk);
      repeat (3) @(negedge wr_clk);
      @(negedge wr_clk) wr_rst_n = 1'b1;
      @(negedge rd_clk) rd_rst_n = 1'b1;
      repeat (2) @(negedge wr_clk);
   endtask

   task automatic test_reset();
      wr_en = 1'b0; rd_en = 1'b0;
      wr_rst_n = 1'b0; rd_rst_n = 1'b0;
      repeat (4) @(negedge rd_clk);
      n_tests++;
      if ({full_n, almost_full, wr_count, wr_overflow} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_wr: {full_n,afull,wr_count,ovf}=%b required %b",
                  {full_n, almost_full, wr_count, wr_overflow}, {1'b1, 1'b0, 5'd0, 1'b0});
      end
      n_tests++;
      if ({empty_n, almost_empty, rd_count, rd_underflow} !== {1'b0, 1'b1, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_rd: {empty_n,aempty,rd_count,unf}=%b required %b",
                  {empty_n, almost_empty, rd_count, rd_underflow}, {1'b0, 1'b1, 5'd0, 1'b0});
      end
      @(negedge wr_clk) wr_rst_n = 1'b1;
      @(negedge rd_clk) rd_rst_n = 1'b1;
      repeat (2) @(negedge wr_clk);
   endtask

   task automatic test_fill();
      int k;
      @(negedge wr_clk);
      for (int i = 1; i <= DEPTH; i++) begin
         push(DW'(i));
         n_tests++;
         if (int'(wr_count) != i) begin
            n_fail++; $display("FAIL fill_wr_count: got %0d required %0d", wr_count, i);
         end
         n_tests++;
         if (almost_full !== (i >= 12)) begin
            n_fail++; $display("FAIL fill_almost_full: count %0d got %b required %b", i, almost_full, (i >= 12));
         end
         n_tests++;
         if (full_n !== (i < DEPTH)) begin
            n_fail++; $display("FAIL fill_full_n: count %0d got %b required %b", i, full_n, (i < DEPTH));
         end
      end
      push(DW'(17));
      n_tests++;
      if ({wr_overflow, full_n, wr_count} !== {1'b1, 1'b0, 5'd16}) begin
         n_fail++;
         $display("FAIL overflow_push: {ovf,full_n,wr_count}=%b required %b", {wr_overflow, full_n, wr_count}, {1'b1, 1'b0, 5'd16});
      end
      k = 0;
      while (k < 20 && rd_count != 5'd16) begin
         @(negedge rd_clk);
         k++;
      end
      n_tests++;
      if ({rd_count, empty_n, almost_empty} !== {5'd16, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL fill_rd_view: {rd_count,empty_n,aempty}=%b required %b", {rd_count, empty_n, almost_empty}, {5'd16, 1'b1, 1'b0});
      end
   endtask

   task automatic test_drain();
      @(negedge rd_clk);
      for (int i = 1; i <= DEPTH; i++) begin
         n_tests++;
         if (empty_n !== 1'b1 || rd_data !== DW'(i)) begin
            n_fail++; $display("FAIL drain_data: empty_n=%b rd_data=%0h required 1 / %0h", empty_n, rd_data, i);
         end
         pop();
         n_tests++;
         if (int'(rd_count) != DEPTH - i || almost_empty !== ((DEPTH - i) <= 2) || empty_n !== (i < DEPTH)) begin
            n_fail++;
            $display("FAIL drain_flags: pop %0d rd_count=%0d aempty=%b empty_n=%b required %0d/%b/%b",
                     i, rd_count, almost_empty, empty_n, DEPTH - i, ((DEPTH - i) <= 2), (i < DEPTH));
         end
      end
      pop();
      n_tests++;
      if ({rd_underflow, rd_count, empty_n} !== {1'b1, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL underflow_pop: {unf,rd_count,empty_n}=%b required %b", {rd_underflow, rd_count, empty_n}, {1'b1, 5'd0, 1'b0});
      end
      repeat (12) @(negedge wr_clk);
      n_tests++;
      if ({wr_count, full_n, almost_full} !== {5'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL drain_wr_view: {wr_count,full_n,afull}=%b required %b", {wr_count, full_n, almost_full}, {5'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_latency();
      logic [DW-1:0] d;
      int            edges;
      d = DW'($urandom);
      @(negedge wr_clk);
      wr_en   = 1'b1;
      wr_data = d;
      @(posedge wr_clk);
      fork
         begin
            @(negedge wr_clk);
            wr_en = 1'b0;
         end
      join_none
      edges = 0;
      while (edges < 8) begin
         @(posedge rd_clk);
         edges++;
         #1;
         if (empty_n) break;
      end
      n_tests++;
      if (empty_n !== 1'b1 || edges > 4) begin
         n_fail++; $display("FAIL latency: empty_n=%b after %0d rd edges, required 1 within 4", empty_n, edges);
      end
      n_tests++;
      if (rd_data !== d) begin
         n_fail++; $display("FAIL latency_data: rd_data=%0h required %0h", rd_data, d);
      end
      @(negedge rd_clk);
      pop();
      n_tests++;
      if (empty_n !== 1'b0) begin
         n_fail++; $display("FAIL latency_pop: empty_n=%b required 0", empty_n);
      end
   endtask

   task automatic test_random(input int n);
      bit ovf_exp, unf_exp;
      do_reset();
      sb.delete();
      push_dec = 0; pop_dec = 0; wr_done = 1'b0;
      ovf_exp = 1'b0; unf_exp = 1'b0;
      fork
         begin
            int            pend, push_com;
            bit            we;
            logic [DW-1:0] d;
            pend = 0; push_com = 0;
            for (int c = 0; c < n; c++) begin
               @(negedge wr_clk);
               if (pend != 0) push_com++;
               pend = 0;
               n_tests++;
               if (int'(wr_count) < push_com - pop_dec || int'(wr_count) > DEPTH) begin
                  n_fail++;
                  $display("FAIL wr_count_bound: wr_count=%0d required between %0d and %0d", wr_count, push_com - pop_dec, DEPTH);
               end
               we = ($urandom_range(0, 99) < 50);
               d  = DW'($urandom);
               if (we && full_n) begin
                  sb.push_back(d);
                  push_dec++;
                  pend = 1;
               end else if (we) begin
                  ovf_exp = 1'b1;
               end
               wr_en   = we;
               wr_data = d;
            end
            @(negedge wr_clk);
            wr_en   = 1'b0;
            wr_done = 1'b1;
         end
         begin
            int            pend, pop_com, cyc;
            bit            re;
            logic [DW-1:0] exp;
            pend = 0; pop_com = 0; cyc = 0;
            while (!(wr_done && sb.size() == 0) && cyc < 20000) begin
               @(negedge rd_clk);
               cyc++;
               if (pend != 0) pop_com++;
               pend = 0;
               n_tests++;
               if (int'(rd_count) > push_dec - pop_com) begin
                  n_fail++; $display("FAIL rd_count_bound: rd_count=%0d required <= %0d", rd_count, push_dec - pop_com);
               end
               re = ($urandom_range(0, 99) < 45);
               if (re && empty_n) begin
                  n_tests++;
                  if (sb.size() == 0) begin
                     n_fail++; $display("FAIL rand_phantom: empty_n=1 rd_data=%0h with no entry expected", rd_data);
                  end else begin
                     exp = sb.pop_front();
                     if (rd_data !== exp) begin
                        n_fail++; $display("FAIL rand_data: rd_data=%0h required %0h", rd_data, exp);
                     end
                  end
                  pop_dec++;
                  pend = 1;
               end else if (re) begin
                  unf_exp = 1'b1;
               end
               rd_en = re;
            end
            @(negedge rd_clk);
            rd_en = 1'b0;
            n_tests++;
            if (cyc >= 20000) begin
               n_fail++; $display("FAIL rand_timeout: %0d entries left after %0d rd cycles, required 0", sb.size(), cyc);
            end
         end
      join
      repeat (2) @(negedge rd_clk);
      n_tests++;
      if ({rd_underflow, empty_n} !== {unf_exp, 1'b0}) begin
         n_fail++; $display("FAIL rand_rd_end: {unf,empty_n}=%b required %b", {rd_underflow, empty_n}, {unf_exp, 1'b0});
      end
      n_tests++;
      if (wr_overflow !== ovf_exp) begin
         n_fail++; $display("FAIL rand_overflow: wr_overflow=%b required %b", wr_overflow, ovf_exp);
      end
   endtask

   task automatic test_mid_reset();
      logic [DW-1:0] q [$];
      logic [DW-1:0] d, exp;
      do_reset();
      @(negedge wr_clk);
      for (int i = 0; i < 8; i++) push(DW'($urandom));
      repeat (12) @(negedge rd_clk);
      n_tests++;
      if ({wr_count, rd_count} !== {5'd8, 5'd8}) begin
         n_fail++; $display("FAIL mid_fill: wr_count=%0d rd_count=%0d required 8/8", wr_count, rd_count);
      end
      wr_rst_n = 1'b0;
      rd_rst_n = 1'b0;
      #1;
      n_tests++;
      if ({full_n, almost_full, wr_count, wr_overflow, empty_n, almost_empty, rd_count, rd_underflow} !==
          {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset_flags: got %b required %b",
                  {full_n, almost_full, wr_count, wr_overflow, empty_n, almost_empty, rd_count, rd_underflow},
                  {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0});
      end
      @(negedge wr_clk) wr_rst_n = 1'b1;
      @(negedge rd_clk) rd_rst_n = 1'b1;
      @(negedge wr_clk);
      for (int i = 0; i < 5; i++) begin
         d = DW'($urandom);
         q.push_back(d);
         push(d);
      end
      repeat (12) @(negedge rd_clk);
      n_tests++;
      if (rd_count !== 5'd5) begin
         n_fail++; $display("FAIL mid_post_count: rd_count=%0d required 5", rd_count);
      end
      while (q.size() != 0) begin
         exp = q.pop_front();
         n_tests++;
         if (rd_data !== exp || empty_n !== 1'b1) begin
            n_fail++; $display("FAIL mid_post_data: rd_data=%0h empty_n=%b required %0h/1", rd_data, empty_n, exp);
         end
         pop();
      end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         if (p == 1) begin
            wr_half = 10;
            rd_half = 4;
         end
         test_reset();
         test_fill();
         test_drain();
         test_latency();
         test_random(1000);
         test_mid_reset();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
